truth_table_checker: RTL and testbench

Synthesizable response checker for small combinational functions under test. It samples each applied input vector together with the DUT output and compares the output against a parameterised expected truth table. It tracks minterm coverage, mismatches and output stability, and reports pass/fail once every minterm has been exercised. It sits on the output side of the function-test harness, opposite the stimulus generator that walks the input combinations.

---
 rtl/tt_chk_pkg.sv | 17 +
 rtl/sat_counter.sv | 33 +++
 rtl/truth_table_checker.sv | 120 ++++++++++++
 tb/tb_truth_table_checker.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tt_chk_pkg.sv
// Shared types and defaults for the truth-table response checker.
// Default table is the 3-input majority function.
package tt_chk_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StComplete
  } tt_state_e;

  localparam int unsigned DefNIn  = 3;
  localparam int unsigned DefCntW = 8;

  // Bit i is F(i); vectors 3, 5, 6 and 7 have at least two ones.
  localparam logic [2**DefNIn-1:0] DefExpected = 8'hE8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/truth_table_checker.sv
// Compares sampled DUT outputs against an expected truth table, tracking coverage,
// mismatches and output stability; reports pass once every input vector has been seen.
module truth_table_checker
  import tt_chk_pkg::*;
#(
  parameter int unsigned          N_IN     = DefNIn,
  parameter logic [2**N_IN-1:0]   EXPECTED = DefExpected,
  parameter int unsigned          CNT_W    = DefCntW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 sample_valid,
  input  logic [N_IN-1:0]      sample_in,
  input  logic                 sample_f,
  output logic                 mismatch,
  output logic [CNT_W-1:0]     err_count,
  output logic [2**N_IN-1:0]   covered,
  output logic [2**N_IN-1:0]   observed,
  output logic                 unstable,
  output logic                 first_err_valid,
  output logic [N_IN-1:0]      first_err_idx,
  output logic                 done,
  output logic                 pass
);

  localparam int unsigned NumVec = 2**N_IN;

  tt_state_e         state_q, state_d;
  logic [NumVec-1:0] covered_q, covered_d;
  logic [NumVec-1:0] observed_q, observed_d;
  logic              mismatch_q, unstable_q, unstable_d;
  logic              first_err_valid_q;
  logic [N_IN-1:0]   first_err_idx_q;
  logic              done_q, pass_q;

  logic accept, bad, flip, all_cov, err_zero_d;

  // clear has priority over a coincident sample, which is simply dropped.
  always_comb begin
    accept     = sample_valid & ~clear;
    bad        = accept && (sample_f != EXPECTED[sample_in]);
    flip       = accept && covered_q[sample_in] && (observed_q[sample_in] != sample_f);
    covered_d  = covered_q;
    observed_d = observed_q;
    if (accept) begin
      covered_d[sample_in]  = 1'b1;
      observed_d[sample_in] = sample_f;
    end
    all_cov    = &covered_d;
    unstable_d = unstable_q | flip;
    err_zero_d = (err_count == '0) && !bad;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (accept) state_d = all_cov ? StComplete : StRun;
      StRun:      if (all_cov) state_d = StComplete;
      StComplete: state_d = StComplete;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      covered_q         <= '0;
      observed_q        <= '0;
      mismatch_q        <= 1'b0;
      unstable_q        <= 1'b0;
      first_err_valid_q <= 1'b0;
      first_err_idx_q   <= '0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
    end else if (clear) begin
      state_q           <= StIdle;
      covered_q         <= '0;
      observed_q        <= '0;
      mismatch_q        <= 1'b0;
      unstable_q        <= 1'b0;
      first_err_valid_q <= 1'b0;
      first_err_idx_q   <= '0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
    end else begin
      state_q    <= state_d;
      covered_q  <= covered_d;
      observed_q <= observed_d;
      mismatch_q <= bad;
      unstable_q <= unstable_d;
      if (bad && !first_err_valid_q) begin
        first_err_valid_q <= 1'b1;
        first_err_idx_q   <= sample_in;
      end
      done_q <= all_cov;
      pass_q <= all_cov && err_zero_d && !unstable_d;
    end
  end

  sat_counter #(
    .Width (CNT_W)
  ) u_err_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clear),
    .inc_i   (bad),
    .count_o (err_count)
  );

  assign mismatch        = mismatch_q;
  assign covered         = covered_q;
  assign observed        = observed_q;
  assign unstable        = unstable_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_idx   = first_err_idx_q;
  assign done            = done_q;
  assign pass            = pass_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: default majority table plus a 2-bit counter copy
// sharing the same stimulus to exercise error-count saturation.
module tb_truth_table_checker;
  import tt_chk_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       sample_valid = 1'b0;
  logic [2:0] sample_in = '0;
  logic       sample_f = 1'b0;

  logic       mismatch, unstable, first_err_valid, done, pass;
  logic [7:0] err_count, covered, observed;
  logic [2:0] first_err_idx;

  logic       mismatch2, unstable2, first_err_valid2, done2, pass2;
  logic [1:0] err_count2;
  logic [7:0] covered2, observed2;
  logic [2:0] first_err_idx2;

  int checks = 0;
  int failures = 0;

  localparam logic [7:0] Maj = 8'hE8;

  always #5 clk = ~clk;

  truth_table_checker dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (clear),
    .sample_valid    (sample_valid),
    .sample_in       (sample_in),
    .sample_f        (sample_f),
    .mismatch        (mismatch),
    .err_count       (err_count),
    .covered         (covered),
    .observed        (observed),
    .unstable        (unstable),
    .first_err_valid (first_err_valid),
    .first_err_idx   (first_err_idx),
    .done            (done),
    .pass            (pass)
  );

  truth_table_checker #(
    .CNT_W (2)
  ) dut2 (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (clear),
    .sample_valid    (sample_valid),
    .sample_in       (sample_in),
    .sample_f        (sample_f),
    .mismatch        (mismatch2),
    .err_count       (err_count2),
    .covered         (covered2),
    .observed        (observed2),
    .unstable        (unstable2),
    .first_err_valid (first_err_valid2),
    .first_err_idx   (first_err_idx2),
    .done            (done2),
    .pass            (pass2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [2:0] idx, input logic f, input logic c);
    sample_valid = v;
    sample_in    = idx;
    sample_f     = f;
    clear        = c;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    clear        = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mismatch"}, 32'(mismatch), 0);
    chk({tag, "_err"}, 32'(err_count), 0);
    chk({tag, "_covered"}, 32'(covered), 0);
    chk({tag, "_observed"}, 32'(observed), 0);
    chk({tag, "_unstable"}, 32'(unstable), 0);
    chk({tag, "_fev"}, 32'(first_err_valid), 0);
    chk({tag, "_fei"}, 32'(first_err_idx), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All vectors with correct majority outputs
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i), Maj[i], 1'b0);
      chk($sformatf("good_mis%0d", i), 32'(mismatch), 0);
      if (i == 6) chk("good_done_early", 32'(done), 0);
    end
    chk("good_covered", 32'(covered), 32'hFF);
    chk("good_observed", 32'(observed), 32'hE8);
    chk("good_err", 32'(err_count), 0);
    chk("good_done", 32'(done), 1);
    chk("good_pass", 32'(pass), 1);
    chk("good_state", 32'(dut.state_q), 32'(StComplete));

    // F stuck at 0: mismatches on 3, 5, 6, 7
    step(1'b0, 3'd0, 1'b0, 1'b1);
    chk("clr_covered", 32'(covered), 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i), 1'b0, 1'b0);
      chk($sformatf("stuck_mis%0d", i), 32'(mismatch), 32'(Maj[i]));
    end
    chk("stuck_err", 32'(err_count), 4);
    chk("stuck_fei", 32'(first_err_idx), 3);
    chk("stuck_fev", 32'(first_err_valid), 1);
    chk("stuck_done", 32'(done), 1);
    chk("stuck_pass", 32'(pass), 0);
    chk("stuck_observed", 32'(observed), 0);

    // Partial coverage with repeats
    step(1'b0, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 3'(i), Maj[i], 1'b0);
    step(1'b1, 3'd4, 1'b0, 1'b0);
    step(1'b1, 3'd4, 1'b0, 1'b0);
    chk("part_done", 32'(done), 0);
    chk("part_covered", 32'(covered), 32'h3F);
    chk("part_pass", 32'(pass), 0);
    chk("part_err", 32'(err_count), 0);
    chk("part_state", 32'(dut.state_q), 32'(StRun));

    // Unstable vector 5
    step(1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b1, 3'd5, 1'b1, 1'b0);
    chk("unst_mis_a", 32'(mismatch), 0);
    step(1'b1, 3'd5, 1'b0, 1'b0);
    chk("unst_mis_b", 32'(mismatch), 1);
    chk("unst_flag", 32'(unstable), 1);
    chk("unst_err", 32'(err_count), 1);
    chk("unst_fei", 32'(first_err_idx), 5);
    for (int i = 0; i < 8; i++) begin
      if (i != 5) step(1'b1, 3'(i), Maj[i], 1'b0);
    end
    chk("unst_done", 32'(done), 1);
    chk("unst_pass", 32'(pass), 0);
    chk("unst_err_end", 32'(err_count), 1);

    // Clear beats a coincident mismatching sample
    step(1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b1, 3'd0, 1'b1, 1'b0);
    step(1'b1, 3'd1, 1'b1, 1'b0);
    step(1'b1, 3'd2, 1'b1, 1'b0);
    chk("pre_clr_err", 32'(err_count), 3);
    step(1'b1, 3'd4, 1'b1, 1'b1);
    chk_reset_vals("clr");

    // Saturation on the 2-bit counter, then asynchronous reset mid-run
    step(1'b1, 3'd0, 1'b1, 1'b0);
    step(1'b1, 3'd1, 1'b1, 1'b0);
    step(1'b1, 3'd2, 1'b1, 1'b0);
    step(1'b1, 3'd3, 1'b0, 1'b0);
    step(1'b1, 3'd4, 1'b1, 1'b0);
    chk("sat_err2", 32'(err_count2), 3);
    chk("sat_err8", 32'(err_count), 5);
    chk("sat_mis2", 32'(mismatch2), 1);
    rst_n = 1'b0;
    #2;
    chk("arst_err2", 32'(err_count2), 0);
    chk("arst_mis2", 32'(mismatch2), 0);
    chk("arst_cov2", 32'(covered2), 0);
    chk("arst_fev2", 32'(first_err_valid2), 0);
    chk_reset_vals("arst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
